// File: rtl/systolic_out_collector_if.sv
// Serialized result stream from the output collector.
// Master drives m_data/m_col/m_valid/m_last; slave drives m_ready.
interface systolic_out_collector_if #(
  parameter int width = 16
);
  logic [width-1:0] m_data;
  logic [5:0]       m_col;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output m_data, m_col, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    input  m_data, m_col, m_valid, m_last,
    output m_ready
  );
endinterface

// File: rtl/systolic_out_collector.sv
// Gathers column-staggered systolic results into a vector and streams it out.
// Ports: clk, nrst (sync active-low), num_filter, out_en[col], systolic_out[col],
//   conv_finish, m (stream master), done (pulse), err (sticky).
// Optional macro COLLECTOR_RELU_EN clamps negative results to 0 on output.
module systolic_out_collector #(
  parameter int width = 16,
  parameter int col   = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [5:0]       num_filter,
  input  logic             out_en       [col],
  input  logic [width-1:0] systolic_out [col],
  input  logic             conv_finish,
  systolic_out_collector_if.master m,
  output logic             done,
  output logic             err
);

  localparam int CW = (col > 1) ? $clog2(col) : 1;
  localparam logic [5:0] COL6 = 6'(col);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t state_q, state_d;

  logic [width-1:0] hold_q [col];
  logic [width-1:0] hold_d [col];
  logic [width-1:0] obuf_q [col];
  logic [width-1:0] obuf_d [col];
  logic [col-1:0]   hv_q, hv_d;
  logic [col-1:0]   act;
  logic             obuf_full_q, obuf_full_d;
  logic             finish_pend_q, finish_pend_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [5:0]       idx_q, idx_d;
  logic [width-1:0] m_data_q, m_data_d;
  logic             m_last_q, m_last_d;

  logic [5:0] n;
  logic [5:0] nxt;
  logic       all_hv;
  logic       last_hs;
  logic       xfer;

  function automatic logic [width-1:0] f(input logic [width-1:0] x);
`ifdef COLLECTOR_RELU_EN
    return x[width-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  assign n = (num_filter > COL6) ? COL6 : num_filter;

  always_comb begin
    act = '0;
    for (int c = 0; c < col; c++) begin
      act[c] = (6'(c) < n);
    end
  end

  assign all_hv  = (n != 6'd0) && ((hv_q & act) == act);
  assign last_hs = (state_q == S_SEND) && m.m_ready && m_last_q;
  // obuf freed by the final beat can be refilled at the same edge
  assign xfer    = all_hv && (!obuf_full_q || last_hs);

  always_comb begin
    hold_d      = hold_q;
    obuf_d      = obuf_q;
    hv_d        = hv_q;
    obuf_full_d = obuf_full_q;
    err_d       = err_q;
    if (xfer) begin
      obuf_d      = hold_q;
      hv_d        = '0;
      obuf_full_d = 1'b1;
    end else if (last_hs) begin
      obuf_full_d = 1'b0;
    end
    for (int c = 0; c < col; c++) begin
      if (act[c] && out_en[c]) begin
        if (!hv_d[c]) begin
          hold_d[c] = systolic_out[c];
          hv_d[c]   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
    // judged after this cycle's captures so a completing strobe survives
    if (conv_finish && (|(hv_d & act)) && ((hv_d & act) != act)) begin
      hv_d  = '0;
      err_d = 1'b1;
    end
  end

  always_comb begin
    done_d = finish_pend_q && !(|hv_q) && !obuf_full_q
             && (state_q == S_IDLE);
    finish_pend_d = conv_finish || (finish_pend_q && !done_d);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (obuf_full_q) state_d = S_SEND;
      S_SEND: if (m.m_ready && m_last_q) state_d = S_IDLE;
    endcase
  end

  assign nxt = idx_q + 6'd1;

  always_comb begin
    idx_d    = idx_q;
    m_data_d = m_data_q;
    m_last_d = m_last_q;
    unique case (state_q)
      S_IDLE: begin
        idx_d    = '0;
        m_data_d = '0;
        m_last_d = 1'b0;
        if (obuf_full_q) begin
          m_data_d = f(obuf_q[0]);
          m_last_d = (n == 6'd1);
        end
      end
      S_SEND: begin
        if (m.m_ready) begin
          if (m_last_q) begin
            idx_d    = '0;
            m_data_d = '0;
            m_last_d = 1'b0;
          end else begin
            idx_d    = nxt;
            m_data_d = f(obuf_q[nxt[CW-1:0]]);
            m_last_d = (nxt == n - 6'd1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      hold_q        <= '{default: '0};
      obuf_q        <= '{default: '0};
      hv_q          <= '0;
      obuf_full_q   <= 1'b0;
      finish_pend_q <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      idx_q         <= '0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      obuf_q        <= obuf_d;
      hv_q          <= hv_d;
      obuf_full_q   <= obuf_full_d;
      finish_pend_q <= finish_pend_d;
      err_q         <= err_d;
      done_q        <= done_d;
      idx_q         <= idx_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
    end
  end

  assign m.m_valid = (state_q == S_SEND);
  assign m.m_data  = m_data_q;
  assign m.m_col   = idx_q;
  assign m.m_last  = m_last_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
